// File: rtl/prog_counter_if.sv
// Control/status bundle for prog_counter. Capture signals exist only when
// PROG_COUNTER_CAPTURE_EN is defined.
interface prog_counter_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 4
);
  logic               enable;
  logic               clear;
  logic               load;
  logic [WIDTH-1:0]   load_value;
  logic               dir;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] prescale;
  logic [WIDTH-1:0]   count;
  logic               tc;
  logic               event_sticky;
  logic               done;
`ifdef PROG_COUNTER_CAPTURE_EN
  logic               capture;
  logic [WIDTH-1:0]   capture_value;
  logic               capture_valid;
`endif

  modport master (
    output enable, clear, load, load_value, dir, mode, limit, prescale,
`ifdef PROG_COUNTER_CAPTURE_EN
    output capture,
    input  capture_value, capture_valid,
`endif
    input  count, tc, event_sticky, done
  );

  modport slave (
    input  enable, clear, load, load_value, dir, mode, limit, prescale,
`ifdef PROG_COUNTER_CAPTURE_EN
    input  capture,
    output capture_value, capture_valid,
`endif
    output count, tc, event_sticky, done
  );
endinterface

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, runtime limit and wrap/saturate/one-shot
// terminal modes. Define PROG_COUNTER_CAPTURE_EN to add the count-capture port group.
module prog_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PRESC_W   = 4,
  parameter int          RST_LIMIT = 2**WIDTH - 1
) (
  input logic             clk,
  input logic             rst,
  prog_counter_if.slave   bus
);

  if (WIDTH < 2 || PRESC_W < 1 || RST_LIMIT < 0) begin : g_param_check
    $error("prog_counter: illegal parameter values");
  end

  typedef enum logic [1:0] {StRun, StSat, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] psc_q, psc_d;
  logic               tc_q, tc_d;
  logic               sticky_q, sticky_d;
  logic               sat_up_q, sat_up_d;

  logic             tick, at_term, mode_sat, mode_one;
  logic [WIDTH-1:0] step_val, end_val, wrap_val;

  assign tick     = bus.enable && (psc_q == bus.prescale);
  assign at_term  = bus.dir ? (count_q >= bus.limit) : (count_q == '0);
  assign mode_sat = (bus.mode == 2'b01);
  assign mode_one = (bus.mode == 2'b10);
  assign step_val = bus.dir ? count_q + 1'b1 : count_q - 1'b1;
  assign end_val  = bus.dir ? bus.limit : '0;
  assign wrap_val = bus.dir ? '0 : bus.limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      count_q  <= '0;
      psc_q    <= '0;
      tc_q     <= 1'b0;
      sticky_q <= 1'b0;
      sat_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      psc_q    <= psc_d;
      tc_q     <= tc_d;
      sticky_q <= sticky_d;
      sat_up_q <= sat_up_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    psc_d    = psc_q;
    tc_d     = 1'b0;
    sticky_d = sticky_q;
    sat_up_d = sat_up_q;
    if (bus.clear) begin
      state_d  = StRun;
      count_d  = '0;
      psc_d    = '0;
      sticky_d = 1'b0;
    end else if (bus.load) begin
      state_d = StRun;
      count_d = bus.load_value;
      psc_d   = '0;
    end else begin
      // psc wraps naturally when prescale was lowered below it
      if (bus.enable) psc_d = tick ? '0 : psc_q + 1'b1;
      unique case (state_q)
        StRun: begin
          if (tick) begin
            if (at_term) begin
              tc_d     = 1'b1;
              sticky_d = 1'b1;
              if (mode_sat) begin
                count_d  = end_val;
                state_d  = StSat;
                sat_up_d = bus.dir;
              end else if (mode_one) begin
                count_d = end_val;
                state_d = StDone;
              end else begin
                count_d = wrap_val;
              end
            end else begin
              count_d = step_val;
            end
          end
        end
        StSat: begin
          if (!mode_sat) begin
            state_d = StRun;
          end else if (tick && (bus.dir != sat_up_q)) begin
            count_d = step_val;
            state_d = StRun;
          end
        end
        StDone:  ;
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    bus.count        = count_q;
    bus.tc           = tc_q;
    bus.event_sticky = sticky_q;
    bus.done         = (state_q == StDone);
  end

`ifdef PROG_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_val_q;
  logic             cap_vld_q;

  // Captures the pre-update count; unaffected by clear
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_val_q <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      cap_vld_q <= bus.capture;
      if (bus.capture) cap_val_q <= count_q;
    end
  end

  always_comb begin
    bus.capture_value = cap_val_q;
    bus.capture_valid = cap_vld_q;
  end
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: each stimulus cycle queues the expected outputs,
// a monitor pops and compares them one clock later.
module tb_prog_counter;
  logic clk;
  logic rst;

  prog_counter_if #(.WIDTH(8), .PRESC_W(4)) bus ();

  prog_counter #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
    logic       sticky;
    logic       done;
    logic [7:0] cap_val;
    logic       cap_vld;
  } obs_t;

  obs_t   exp_q[$];
  string  name_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  logic [7:0] exp_cap_val = '0;
  logic       exp_cap_vld = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input string name, input logic [7:0] ec, input logic etc,
                     input logic es, input logic ed);
    obs_t e;
    e.count   = ec;
    e.tc      = etc;
    e.sticky  = es;
    e.done    = ed;
    e.cap_val = exp_cap_val;
    e.cap_vld = exp_cap_vld;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    obs_t  e, a;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a.count  = bus.count;
        a.tc     = bus.tc;
        a.sticky = bus.event_sticky;
        a.done   = bus.done;
`ifdef PROG_COUNTER_CAPTURE_EN
        a.cap_val = bus.capture_value;
        a.cap_vld = bus.capture_valid;
`else
        a.cap_val = '0;
        a.cap_vld = 1'b0;
`endif
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got count=%0d tc=%b sticky=%b done=%b cap=%0d/%b, required count=%0d tc=%b sticky=%b done=%b cap=%0d/%b",
                   n, a.count, a.tc, a.sticky, a.done, a.cap_val, a.cap_vld,
                   e.count, e.tc, e.sticky, e.done, e.cap_val, e.cap_vld);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.clear = 1'b0; bus.load = 1'b0; bus.load_value = '0;
    bus.dir = 1'b1; bus.mode = 2'b00; bus.limit = 8'd5; bus.prescale = '0;
`ifdef PROG_COUNTER_CAPTURE_EN
    bus.capture = 1'b0;
`endif
    cyc("reset0", 0, 0, 0, 0);
    cyc("reset1", 0, 0, 0, 0);

    // Wrap up to limit 5
    rst = 1'b0; bus.enable = 1'b1;
    for (int i = 1; i <= 5; i++) cyc("wrap_up", 8'(i), 0, 0, 0);
    cyc("wrap_tc", 0, 1, 1, 0);
    cyc("wrap_after", 1, 0, 1, 0);

    // Prescale by 3 with an enable gap
    bus.limit = 8'd100; bus.prescale = 4'd2;
    cyc("psc_a", 1, 0, 1, 0);
    cyc("psc_b", 1, 0, 1, 0);
    cyc("psc_tick", 2, 0, 1, 0);
    cyc("psc_c", 2, 0, 1, 0);
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) cyc("psc_frozen", 2, 0, 1, 0);
    bus.enable = 1'b1;
    cyc("psc_resume", 2, 0, 1, 0);
    cyc("psc_resume_tick", 3, 0, 1, 0);
    cyc("psc_resume_after", 3, 0, 1, 0);

    // Down one-shot
    bus.prescale = '0; bus.load = 1'b1; bus.load_value = 8'd3; bus.dir = 1'b0;
    bus.mode = 2'b10;
    cyc("os_load", 3, 0, 1, 0);
    bus.load = 1'b0;
    cyc("os_2", 2, 0, 1, 0);
    cyc("os_1", 1, 0, 1, 0);
    cyc("os_0", 0, 0, 1, 0);
    cyc("os_term", 0, 1, 1, 1);
    cyc("os_hold_a", 0, 0, 1, 1);
    cyc("os_hold_b", 0, 0, 1, 1);
    bus.load = 1'b1; bus.load_value = 8'd7;
    cyc("os_reload", 7, 0, 1, 0);
    bus.load = 1'b0;
    cyc("os_resume", 6, 0, 1, 0);

    // Saturate then reverse
    bus.clear = 1'b1;
    cyc("sat_clear", 0, 0, 0, 0);
    bus.clear = 1'b0; bus.limit = 8'd4; bus.mode = 2'b01; bus.dir = 1'b1;
    for (int i = 1; i <= 4; i++) cyc("sat_up", 8'(i), 0, 0, 0);
    cyc("sat_term", 4, 1, 1, 0);
    cyc("sat_hold_a", 4, 0, 1, 0);
    cyc("sat_hold_b", 4, 0, 1, 0);
    bus.dir = 1'b0;
    cyc("sat_reverse", 3, 0, 1, 0);
    cyc("sat_run_down", 2, 0, 1, 0);
    bus.dir = 1'b1;
    cyc("sat_up3", 3, 0, 1, 0);
    cyc("sat_up4", 4, 0, 1, 0);
    cyc("sat_term2", 4, 1, 1, 0);
    bus.mode = 2'b00;
    cyc("sat_mode_exit", 4, 0, 1, 0);
    cyc("sat_then_wrap", 0, 1, 1, 0);

    // Priority
    bus.clear = 1'b1; bus.load = 1'b1; bus.load_value = 8'd9;
    cyc("prio_clear", 0, 0, 0, 0);
    bus.clear = 1'b0; bus.load = 1'b0;
    for (int i = 1; i <= 4; i++) cyc("prio_up", 8'(i), 0, 0, 0);
    bus.load = 1'b1;
    cyc("prio_load_over_tc", 9, 0, 0, 0);
    bus.load = 1'b0;
    cyc("prio_above_limit", 0, 1, 1, 0);
    bus.limit = 8'd0;
    cyc("limit0_a", 0, 1, 1, 0);
    cyc("limit0_b", 0, 1, 1, 0);

`ifdef PROG_COUNTER_CAPTURE_EN
    bus.enable = 1'b0; bus.limit = 8'd100; bus.load = 1'b1; bus.load_value = 8'd9;
    cyc("cap_load", 9, 0, 1, 0);
    bus.load = 1'b0; bus.capture = 1'b1;
    exp_cap_val = 8'd9; exp_cap_vld = 1'b1;
    cyc("cap_pulse", 9, 0, 1, 0);
    bus.capture = 1'b0; exp_cap_vld = 1'b0;
    cyc("cap_drop", 9, 0, 1, 0);
`endif

    // Reset while saturated
    bus.clear = 1'b1;
    cyc("pre_rst_clear", 0, 0, 0, 0);
    bus.clear = 1'b0; bus.enable = 1'b1; bus.limit = 8'd4; bus.mode = 2'b01;
    bus.dir = 1'b1; bus.load = 1'b1; bus.load_value = 8'd4;
    cyc("rst_load", 4, 0, 0, 0);
    bus.load = 1'b0;
    cyc("rst_sat", 4, 1, 1, 0);
    rst = 1'b1;
    exp_cap_val = '0;
    cyc("rst_all_zero", 0, 0, 0, 0);
    rst = 1'b0;
    cyc("rst_fsm_run", 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised successor to the basic enable/overflow counter.
- Adds:
  - up/down direction
  - a runtime terminal value (limit)
  - a clock-enable prescaler
  - synchronous clear and parallel load
  - three terminal modes (wrap, saturate, one-shot), sequenced by a small FSM
- Used as the general timer/event-count primitive in control and datapath blocks.

Parameters:
- WIDTH, 8: count, limit and load_value width in bits (≥2).
- PRESC_W, 4: prescale field width in bits (≥1).
- RST_LIMIT, 2**WIDTH-1: reserved for integrators; not used by this block's logic.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  count enable; the prescaler advances only while high.
- clear  input  1  synchronous clear of count, prescaler, FSM and sticky flag.
- load  input  1  parallel load of load_value.
- load_value  input  WIDTH  value taken on load.
- dir  input  1  1 = count up, 0 = count down.
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- limit  input  WIDTH  terminal value, sampled every cycle.
- prescale  input  PRESC_W  one tick per (prescale+1) enabled cycles.
- count  output  WIDTH  current count, registered.
- tc  output  1  one-cycle pulse on a terminal event, registered.
- event_sticky  output  1  set by any tc; cleared only by rst or clear.
- done  output  1  high while the FSM is in DONE.

Behaviour:
- Reset: rst=1 → count=0, tc=0, event_sticky=0, done=0, prescaler=0, FSM=RUN.
- Priority per cycle: rst > clear > load > tick.
- clear: count=0, prescaler=0, FSM=RUN, tc=0, event_sticky=0.
- load: count=load_value, prescaler=0, FSM=RUN, tc=0; event_sticky is unchanged. load_value>limit is legal.
- Prescaler:
  - internal psc, width PRESC_W.
  - enable=0 → psc holds; no tick.
  - enable=1 and psc==prescale → tick, psc=0.
  - otherwise psc+1.
  - prescale=0 gives one tick every enabled cycle.
  - A prescale change mid-count takes effect on the next compare. If psc>prescale after the change, psc counts until it wraps naturally; no spurious tick.
- Terminal condition on a tick:
  - up: count ≥ limit.
  - down: count == 0.
- Non-terminal tick: count ± 1, tc=0.
- Terminal tick in RUN:
  - wrap: count=0 (up) or count=limit (down); tc=1; stay RUN.
  - saturate: count=limit (up) or 0 (down); tc=1; go to SAT.
  - one-shot: same count update as saturate; tc=1; done=1; go to DONE.
- SAT state:
  - Ticks in the stored direction are ignored; no tc.
  - A tick with dir pointing away from the terminal (e.g. held at limit and dir=0) does the normal ±1 and returns to RUN.
  - mode≠saturate returns to RUN on the next cycle, with no count change that cycle.
- DONE state:
  - All ticks are ignored; done stays high.
  - Exit to RUN only via clear, load or rst; done drops in the same cycle as the state change.
- Latency: count and tc update one clock after the tick-qualifying edge. tc and the count update are coincident.
- Runtime limit/dir/mode changes: no reset of state; they are evaluated at the next tick.
- limit=0 with up and wrap: every tick is terminal, count stays 0, tc pulses on every tick.
- Arithmetic is modulo 2^WIDTH internally, but can never wrap past limit/0 except through the terminal rules above.
- rst or clear mid-prescale discards the partial prescale interval.

Optional Feature:
- Macro: PROG_COUNTER_CAPTURE_EN.
- When defined, adds three ports:
  - capture  input  1
  - capture_value  output  WIDTH
  - capture_valid  output  1
- capture=1 latches the pre-update count of that cycle into capture_value. capture_valid pulses for one cycle, one clock later.
- Capture is independent of enable, tick and FSM state.
- rst clears capture_value and capture_valid; clear does not affect them.
- When undefined, these ports and their logic are absent; the remaining behaviour is identical.

Test Plan:
- Wrap up: WIDTH=8, limit=5, prescale=0, enable=1, dir=1, mode=00 from reset → count 0,1,2,3,4,5,0. tc=1 only on the 5→0 cycle; event_sticky=1 from then on.
- Prescaler: prescale=2, enable=1 → count increments every 3rd cycle. Deassert enable for 4 cycles mid-interval → psc and count frozen, then resume at the same phase.
- Down/one-shot: load_value=3, dir=0, mode=10 → count 3,2,1,0 with tc and done=1 on reaching 0. Further ticks leave count=0 and tc=0. load of 7 → done=0, counting resumes from 7.
- Saturate and reverse: limit=4, mode=01, up → count sticks at 4 with tc once. Set dir=0 → count 3, FSM back to RUN, no tc.
- Priority: assert clear, load and a tick in the same cycle → count=0, event_sticky=0. Assert load with a terminal tick → count=load_value, tc=0.
- Capture (PROG_COUNTER_CAPTURE_EN): capture while count=9 → next cycle capture_value=9, capture_valid=1 for exactly one cycle. Assert rst with mode=01 at count=limit → all outputs 0, FSM=RUN.
